// File: rtl/led_step_ctrl_pkg.sv
// Speed codes and the rate table shared by the running-light step controller.
package led_step_ctrl_pkg;

  localparam logic [1:0] SPD_HALF = 2'd0;
  localparam logic [1:0] SPD_QTR  = 2'd1;
  localparam logic [1:0] SPD_8TH  = 2'd2;
  localparam logic [1:0] SPD_1S   = 2'd3;

  localparam int NUM_KEYS  = 2;
  localparam int KEY_SPEED = 0;
  localparam int KEY_PAUSE = 1;

  // Step period in clock cycles for a speed code, relative to the speed-0 period.
  function automatic int unsigned step_period(input logic [1:0] sel, input int unsigned base);
    int unsigned p;
    case (sel)
      SPD_HALF: p = base;
      SPD_QTR:  p = base / 2;
      SPD_8TH:  p = base / 4;
      SPD_1S:   p = base * 2;
      default:  p = base;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_step_ctrl_key_debounce.sv
// Key front end: 2-FF synchronizer, counter debouncer and one-cycle press pulse
// on the debounced 1->0 transition of an active-low key.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk_50,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;
  logic          settle;

  // The synced level has differed long enough: accept it this cycle.
  assign settle = (sync2_reg != stable_reg) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk_50) begin
    if (rst) begin
      sync1_reg  <= 1'b1;
      sync2_reg  <= 1'b1;
      stable_reg <= 1'b1;
      press_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      press_reg <= settle && stable_reg;
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (settle) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/led_step_ctrl.sv
// Step-tick generator for the running-light shifter: debounced speed and
// run/pause keys drive a prescaler that emits one-cycle step ticks.
module led_step_ctrl
  import led_step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned BASE_PERIOD  = 25_000_000,
  parameter int          CNT_W        = 27
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       key_speed_n,
  input  logic       key_pause_n,
  output logic       step_tick,
  output logic [1:0] speed_sel,
  output logic       running
);

  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] press;

  assign key_n[KEY_SPEED] = key_speed_n;
  assign key_n[KEY_PAUSE] = key_pause_n;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_key (
        .clk_50(clk_50),
        .rst   (rst),
        .key_n (key_n[gi]),
        .press (press[gi])
      );
    end
  endgenerate

  logic [CNT_W-1:0] prescaler_reg;
  logic [CNT_W-1:0] term_cnt;
  logic [1:0]       speed_sel_reg;
  logic             running_reg;
  logic             step_tick_reg;

  assign term_cnt = CNT_W'(step_period(speed_sel_reg, BASE_PERIOD) - 1);

  // A key press cycle never advances the prescaler: a speed change restarts
  // the period, and a pause toggle leaves the partial period intact.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      prescaler_reg <= '0;
      speed_sel_reg <= SPD_HALF;
      running_reg   <= 1'b1;
      step_tick_reg <= 1'b0;
    end else begin
      step_tick_reg <= 1'b0;
      if (press[KEY_SPEED]) begin
        speed_sel_reg <= speed_sel_reg + 2'd1;
        prescaler_reg <= '0;
      end else if (running_reg && !press[KEY_PAUSE]) begin
        if (prescaler_reg == term_cnt) begin
          prescaler_reg <= '0;
          step_tick_reg <= 1'b1;
        end else begin
          prescaler_reg <= prescaler_reg + CNT_W'(1);
        end
      end
      if (press[KEY_PAUSE]) begin
        running_reg <= ~running_reg;
      end
    end
  end

  assign step_tick = step_tick_reg;
  assign speed_sel = speed_sel_reg;
  assign running   = running_reg;

endmodule
